// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register of the MIPS pipeline. Captures the
//                decoded instruction and presents registered opcode, funct,
//                operands and write destination to the execute stage (ALU
//                control decoder). Inserts bubbles on flush and on load-use
//                hazards, holds on downstream stall, and drives the
//                fetch/decode hold signal upstream.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Build option:
//    LOAD_USE_STALL_EN  defined   -> load-use hazard detection, STALL state
//                                    and bubble counter are active.
//                       undefined -> hazard tied low, stage always in RUN,
//                                    LOAD_USE_BUBBLES has no effect
//                                    (software schedules around load-use).
// ----------------------------------------------------------------------------
//  Parameters:
//    DATA_W            operand / immediate / PC width
//    LOAD_USE_BUBBLES  bubbles inserted per load-use hazard (1..3)
//  Ports:
//    clk, rst                 clock, synchronous active-high reset
//    ID_*                     decoded instruction from the decode stage
//    flush                    branch/jump redirect, kills the decode slot
//    ext_stall                memory-stage stall, freezes this stage
//    EXE_*                    registered instruction for the execute stage
//    hold_fetch               combinational; PC and IF/ID must not advance
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W           = 32,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  // decode stage
  input  logic              ID_valid,
  input  logic [3:0]        ID_opcode,
  input  logic [5:0]        ID_funct,
  input  logic [4:0]        ID_rs,
  input  logic [4:0]        ID_rt,
  input  logic [4:0]        ID_rd,
  input  logic [4:0]        ID_shamt,
  input  logic [DATA_W-1:0] ID_rs_data,
  input  logic [DATA_W-1:0] ID_rt_data,
  input  logic [DATA_W-1:0] ID_imm,
  input  logic [DATA_W-1:0] ID_pc,
  input  logic              ID_reg_write,
  // pipeline control
  input  logic              flush,
  input  logic              ext_stall,
  // execute stage
  output logic              EXE_valid,
  output logic              EXE_reg_write,
  output logic [3:0]        EXE_opcode,
  output logic [5:0]        EXE_funct,
  output logic [4:0]        EXE_rs,
  output logic [4:0]        EXE_rt,
  output logic [4:0]        EXE_rd,
  output logic [4:0]        EXE_shamt,
  output logic [4:0]        EXE_dest,
  output logic [DATA_W-1:0] EXE_rs_data,
  output logic [DATA_W-1:0] EXE_rt_data,
  output logic [DATA_W-1:0] EXE_imm,
  output logic [DATA_W-1:0] EXE_pc,
  // upstream
  output logic              hold_fetch
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [3:0] OP_RTYPE  = 4'd2;
  localparam logic [3:0] OP_JAL    = 4'd7;
  localparam logic [5:0] FN_LOAD   = 6'h21;
  localparam logic [4:0] LINK_REG  = 5'd31;
  localparam logic [4:0] ZERO_REG  = 5'd0;

  localparam logic [0:0] RUN       = 1'b0;
  localparam logic [0:0] STALL     = 1'b1;

  // Counter preload when entering STALL: the hazard cycle itself is the
  // first bubble, STALL supplies the remaining LOAD_USE_BUBBLES-1, and it
  // leaves when cnt reaches zero, hence the "-2". A single bubble never
  // enters STALL, so the preload is irrelevant there.
  localparam logic [1:0] CNT_INIT  = (LOAD_USE_BUBBLES >= 2) ?
                                     2'(LOAD_USE_BUBBLES - 2) : 2'd0;
  localparam bit         MULTI_BUB = (LOAD_USE_BUBBLES >= 2);

  // --------------------------------------------------------------------------
  // Write destination, resolved at capture so EXE_dest is a clean flop
  // --------------------------------------------------------------------------
  logic [4:0] id_dest;

  always_comb begin
    id_dest = ID_rt;
    if (ID_opcode == OP_RTYPE) begin
      id_dest = ID_rd;
    end else if (ID_opcode == OP_JAL) begin
      id_dest = LINK_REG;
    end
  end

  // --------------------------------------------------------------------------
  // Load-use hazard detection
  // --------------------------------------------------------------------------
  logic hazard;

`ifdef LOAD_USE_STALL_EN
  logic exe_is_load;
  logic src_match;

  assign exe_is_load = EXE_valid && (EXE_opcode == OP_RTYPE) &&
                       (EXE_funct == FN_LOAD);
  assign src_match   = (ID_rs == EXE_dest) || (ID_rt == EXE_dest);

  // A load into $zero produces nothing to forward-wait on.
  assign hazard      = exe_is_load && EXE_reg_write &&
                       (EXE_dest != ZERO_REG) && ID_valid && src_match;
`else
  // Load-use ordering is the compiler's job in this build.
  assign hazard      = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Stall state machine
  // With hazard tied low the machine never leaves RUN and folds away.
  // --------------------------------------------------------------------------
  logic [0:0] state;
  logic [1:0] cnt;
  logic       in_run;
  logic       in_stall;
  logic       run_hazard;

  assign in_run     = (state == RUN);
  assign in_stall   = (state == STALL);
  assign run_hazard = in_run && hazard;   // hazard is ignored during STALL

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else if (flush) begin
      // redirect abandons any pending load-use bubbles
      state <= RUN;
      cnt   <= 2'd0;
    end else if (ext_stall) begin
      state <= state;
      cnt   <= cnt;
    end else if (in_stall) begin
      if (cnt == 2'd0) begin
        state <= RUN;
      end else begin
        cnt   <= cnt - 2'd1;
      end
    end else if (run_hazard && MULTI_BUB) begin
      state <= STALL;
      cnt   <= CNT_INIT;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline register
  // --------------------------------------------------------------------------
  logic kill;      // force a bubble this edge
  logic bubble;    // nothing valid to capture

  assign kill   = rst || flush;
  assign bubble = in_stall || run_hazard || !ID_valid;

  always_ff @(posedge clk) begin
    if (kill || (!ext_stall && bubble)) begin
      EXE_valid     <= 1'b0;
      EXE_reg_write <= 1'b0;
      EXE_opcode    <= 4'd0;
      EXE_funct     <= 6'd0;
      EXE_rs        <= 5'd0;
      EXE_rt        <= 5'd0;
      EXE_rd        <= 5'd0;
      EXE_shamt     <= 5'd0;
      EXE_dest      <= 5'd0;
      EXE_rs_data   <= '0;
      EXE_rt_data   <= '0;
      EXE_imm       <= '0;
      EXE_pc        <= '0;
    end else if (!ext_stall) begin
      EXE_valid     <= 1'b1;
      EXE_reg_write <= ID_reg_write;
      EXE_opcode    <= ID_opcode;
      EXE_funct     <= ID_funct;
      EXE_rs        <= ID_rs;
      EXE_rt        <= ID_rt;
      EXE_rd        <= ID_rd;
      EXE_shamt     <= ID_shamt;
      EXE_dest      <= id_dest;
      EXE_rs_data   <= ID_rs_data;
      EXE_rt_data   <= ID_rt_data;
      EXE_imm       <= ID_imm;
      EXE_pc        <= ID_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Upstream hold. Flush overrides everything so the redirect target can be
  // fetched; reset keeps it low so fetch restarts cleanly.
  // --------------------------------------------------------------------------
  assign hold_fetch = !rst && !flush &&
                      (ext_stall || in_stall || run_hazard);

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Directed self-checking bench for id_ex_stage. Two instances
//                share stimulus: one with a single load-use bubble, one with
//                three. Expectations follow the LOAD_USE_STALL_EN build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

`ifdef LOAD_USE_STALL_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  localparam int W  = 32;
  localparam int BW = 165;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, ext_stall;
  logic          id_valid, id_rw;
  logic [3:0]    id_op;
  logic [5:0]    id_fn;
  logic [4:0]    id_rs, id_rt, id_rd, id_sh;
  logic [W-1:0]  id_rsd, id_rtd, id_imm, id_pc;

  logic          v1_valid, v1_rw, v3_valid, v3_rw, hold1, hold3;
  logic [3:0]    v1_op, v3_op;
  logic [5:0]    v1_fn, v3_fn;
  logic [4:0]    v1_rs, v1_rt, v1_rd, v1_sh, v1_dest;
  logic [4:0]    v3_rs, v3_rt, v3_rd, v3_sh, v3_dest;
  logic [W-1:0]  v1_rsd, v1_rtd, v1_imm, v1_pc;
  logic [W-1:0]  v3_rsd, v3_rtd, v3_imm, v3_pc;

  id_ex_stage #(.DATA_W(W), .LOAD_USE_BUBBLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .ID_valid(id_valid), .ID_opcode(id_op), .ID_funct(id_fn),
    .ID_rs(id_rs), .ID_rt(id_rt), .ID_rd(id_rd), .ID_shamt(id_sh),
    .ID_rs_data(id_rsd), .ID_rt_data(id_rtd), .ID_imm(id_imm), .ID_pc(id_pc),
    .ID_reg_write(id_rw), .flush(flush), .ext_stall(ext_stall),
    .EXE_valid(v1_valid), .EXE_reg_write(v1_rw), .EXE_opcode(v1_op),
    .EXE_funct(v1_fn), .EXE_rs(v1_rs), .EXE_rt(v1_rt), .EXE_rd(v1_rd),
    .EXE_shamt(v1_sh), .EXE_dest(v1_dest), .EXE_rs_data(v1_rsd),
    .EXE_rt_data(v1_rtd), .EXE_imm(v1_imm), .EXE_pc(v1_pc),
    .hold_fetch(hold1)
  );

  id_ex_stage #(.DATA_W(W), .LOAD_USE_BUBBLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .ID_valid(id_valid), .ID_opcode(id_op), .ID_funct(id_fn),
    .ID_rs(id_rs), .ID_rt(id_rt), .ID_rd(id_rd), .ID_shamt(id_sh),
    .ID_rs_data(id_rsd), .ID_rt_data(id_rtd), .ID_imm(id_imm), .ID_pc(id_pc),
    .ID_reg_write(id_rw), .flush(flush), .ext_stall(ext_stall),
    .EXE_valid(v3_valid), .EXE_reg_write(v3_rw), .EXE_opcode(v3_op),
    .EXE_funct(v3_fn), .EXE_rs(v3_rs), .EXE_rt(v3_rt), .EXE_rd(v3_rd),
    .EXE_shamt(v3_sh), .EXE_dest(v3_dest), .EXE_rs_data(v3_rsd),
    .EXE_rt_data(v3_rtd), .EXE_imm(v3_imm), .EXE_pc(v3_pc),
    .hold_fetch(hold3)
  );

  logic [BW-1:0] o1, o3;
  assign o1 = {v1_valid, v1_rw, v1_op, v1_fn, v1_rs, v1_rt, v1_rd, v1_sh,
               v1_dest, v1_rsd, v1_rtd, v1_imm, v1_pc};
  assign o3 = {v3_valid, v3_rw, v3_op, v3_fn, v3_rs, v3_rt, v3_rd, v3_sh,
               v3_dest, v3_rsd, v3_rtd, v3_imm, v3_pc};

  int npass = 0;
  int ntotal = 0;

  function automatic logic [BW-1:0] mk(
    input logic v, input logic rw, input logic [3:0] op, input logic [5:0] fn,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic [4:0] sh, input logic [4:0] dest, input logic [W-1:0] rsd,
    input logic [W-1:0] rtd, input logic [W-1:0] imm, input logic [W-1:0] pc);
    return {v, rw, op, fn, rs, rt, rd, sh, dest, rsd, rtd, imm, pc};
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic setid(input logic v, input logic rw, input logic [3:0] op,
                       input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [W-1:0] rsd, input logic [W-1:0] rtd,
                       input logic [W-1:0] imm, input logic [W-1:0] pc);
    id_valid = v;  id_rw = rw;  id_op = op;  id_fn = fn;
    id_rs = rs;    id_rt = rt;  id_rd = rd;  id_sh = 5'd0;
    id_rsd = rsd;  id_rtd = rtd; id_imm = imm; id_pc = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expected bundles
  logic [BW-1:0] BUB, e_add, e_jal, e_ld, e_dep, e_ld0, e_dep0, e_sub;

  initial begin
    BUB    = '0;
    e_add  = mk(1, 1, 4'd2, 6'h20, 5'd1, 5'd3, 5'd5, 5'd0, 5'd5,  32'd7,  32'd2, 32'd0,   32'd4);
    e_jal  = mk(1, 1, 4'd7, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 32'd0,  32'd0, 32'h40,  32'd8);
    e_ld   = mk(1, 1, 4'd2, 6'h21, 5'd2, 5'd0, 5'd8, 5'd0, 5'd8,  32'd5,  32'd0, 32'd4,   32'd12);
    e_dep  = mk(1, 1, 4'd2, 6'h20, 5'd8, 5'd1, 5'd9, 5'd0, 5'd9,  32'd50, 32'd6, 32'd0,   32'd16);
    e_ld0  = mk(1, 1, 4'd2, 6'h21, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0,  32'd5,  32'd0, 32'd4,   32'd20);
    e_dep0 = mk(1, 1, 4'd2, 6'h20, 5'd0, 5'd1, 5'd9, 5'd0, 5'd9,  32'd50, 32'd6, 32'd0,   32'd24);
    e_sub  = mk(1, 1, 4'd2, 6'h22, 5'd1, 5'd2, 5'd4, 5'd0, 5'd4,  32'd10, 32'd3, 32'd0,   32'd100);

    // ---- reset with a live instruction on the decode side ----
    rst = 1'b1; flush = 1'b0; ext_stall = 1'b0;
    setid(1, 1, 4'd4, 6'h00, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd3, 32'd0);
    step(); step();
    check("reset_exe1", o1, BUB);
    check("reset_exe3", o3, BUB);
    check1("reset_hold1", hold1, 1'b0);
    check1("reset_hold3", hold3, 1'b0);

    // ---- pass-through ----
    rst = 1'b0;
    setid(1, 1, 4'd2, 6'h20, 5'd1, 5'd3, 5'd5, 32'd7, 32'd2, 32'd0, 32'd4);
    #1 check1("post_reset_hold", hold1, 1'b0);
    step();
    check("pass_add1", o1, e_add);
    check("pass_add3", o3, e_add);
    setid(1, 1, 4'd7, 6'h00, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h40, 32'd8);
    step();
    check("pass_jal_dest31", o1, e_jal);

    // ---- ID_valid low captures a bubble ----
    setid(0, 1, 4'd2, 6'h20, 5'd1, 5'd3, 5'd5, 32'd7, 32'd2, 32'd0, 32'd4);
    step();
    check("invalid_bubble", o1, BUB);

    // ---- load-use ----
    setid(1, 1, 4'd2, 6'h21, 5'd2, 5'd0, 5'd8, 32'd5, 32'd0, 32'd4, 32'd12);
    step();
    check("lu_load1", o1, e_ld);
    setid(1, 1, 4'd2, 6'h20, 5'd8, 5'd1, 5'd9, 32'd50, 32'd6, 32'd0, 32'd16);
    #1;
    check1("lu_hold1_c0", hold1, EN);
    check1("lu_hold3_c0", hold3, EN);
    step();
    check("lu_e2_dut1", o1, EN ? BUB : e_dep);
    check("lu_e2_dut3", o3, EN ? BUB : e_dep);
    check1("lu_hold1_c1", hold1, 1'b0);
    check1("lu_hold3_c1", hold3, EN);
    step();
    check("lu_e3_dut1", o1, e_dep);
    check("lu_e3_dut3", o3, EN ? BUB : e_dep);
    check1("lu_hold3_c2", hold3, EN);
    step();
    check("lu_e4_dut3", o3, EN ? BUB : e_dep);
    check1("lu_hold3_c3", hold3, 1'b0);
    step();
    check("lu_e5_dut3", o3, e_dep);

    // ---- load to $zero never stalls ----
    setid(1, 1, 4'd2, 6'h21, 5'd2, 5'd0, 5'd0, 32'd5, 32'd0, 32'd4, 32'd20);
    step();
    check("lz_load", o1, e_ld0);
    setid(1, 1, 4'd2, 6'h20, 5'd0, 5'd1, 5'd9, 32'd50, 32'd6, 32'd0, 32'd24);
    #1;
    check1("lz_hold1", hold1, 1'b0);
    check1("lz_hold3", hold3, 1'b0);
    step();
    check("lz_dep1", o1, e_dep0);
    check("lz_dep3", o3, e_dep0);

    // ---- flush during STALL ----
    setid(1, 1, 4'd2, 6'h21, 5'd2, 5'd0, 5'd8, 32'd5, 32'd0, 32'd4, 32'd12);
    step();
    setid(1, 1, 4'd2, 6'h20, 5'd8, 5'd1, 5'd9, 32'd50, 32'd6, 32'd0, 32'd16);
    step();
    check("fl_e2_dut3", o3, EN ? BUB : e_dep);
    flush = 1'b1;
    #1;
    check1("fl_hold3", hold3, 1'b0);
    check1("fl_hold1", hold1, 1'b0);
    step();
    check("fl_bubble3", o3, BUB);
    check("fl_bubble1", o1, BUB);
    flush = 1'b0;
    #1 check1("fl_after_hold3", hold3, 1'b0);
    step();
    check("fl_recapture3", o3, e_dep);
    check("fl_recapture1", o1, e_dep);

    // ---- ext_stall freezes the stage ----
    setid(1, 1, 4'd2, 6'h22, 5'd1, 5'd2, 5'd4, 32'd10, 32'd3, 32'd0, 32'd100);
    step();
    check("es_sub", o1, e_sub);
    ext_stall = 1'b1;
    setid(1, 1, 4'd2, 6'h20, 5'd1, 5'd3, 5'd5, 32'd7, 32'd2, 32'd0, 32'd4);
    #1 check1("es_hold_c0", hold1, 1'b1);
    step();
    check("es_keep1_c1", o1, e_sub);
    check("es_keep3_c1", o3, e_sub);
    check1("es_hold_c1", hold3, 1'b1);
    step();
    check("es_keep1_c2", o1, e_sub);
    flush = 1'b1;
    #1;
    check1("es_flush_hold1", hold1, 1'b0);
    check1("es_flush_hold3", hold3, 1'b0);
    step();
    check("es_flush_bub1", o1, BUB);
    check("es_flush_bub3", o3, BUB);
    flush = 1'b0; ext_stall = 1'b0;

    // ---- reset in the middle of STALL ----
    setid(1, 1, 4'd2, 6'h21, 5'd2, 5'd0, 5'd8, 32'd5, 32'd0, 32'd4, 32'd12);
    step();
    setid(1, 1, 4'd2, 6'h20, 5'd8, 5'd1, 5'd9, 32'd50, 32'd6, 32'd0, 32'd16);
    step();
    rst = 1'b1;
    #1 check1("rs_hold_in_reset", hold3, 1'b0);
    step();
    check("rs_bubble3", o3, BUB);
    rst = 1'b0;
    #1 check1("rs_hold_after", hold3, 1'b0);
    step();
    check("rs_capture3", o3, e_dep);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the MIPS pipeline. It captures the decoded instruction from the decode stage and presents registered opcode, funct, operands and destination to the execute stage, directly feeding the ALU control decoder. It inserts bubbles on flush and on load-use hazards (via a small stall state machine), and holds on downstream stall. It drives the fetch/decode hold signal upstream.

## Interface
Parameters:
- DATA_W, 32, operand/immediate/PC width
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ID_valid  in  1  decode slot holds a real instruction
- ID_opcode  in  4  decoded opcode
- ID_funct  in  6  function field
- ID_rs, ID_rt, ID_rd, ID_shamt  in  5 each  register/shift fields
- ID_rs_data, ID_rt_data  in  DATA_W  register file read data
- ID_imm, ID_pc  in  DATA_W  extended immediate, instruction PC
- ID_reg_write  in  1  instruction writes the register file
- flush  in  1  branch/jump redirect, kill decode slot
- ext_stall  in  1  memory stage stall, freeze this stage
- EXE_valid, EXE_reg_write  out  1  registered copies
- EXE_opcode  out  4, EXE_funct  out  6  to ALU control
- EXE_rs, EXE_rt, EXE_rd, EXE_shamt, EXE_dest  out  5  fields and write destination
- EXE_rs_data, EXE_rt_data, EXE_imm, EXE_pc  out  DATA_W  registered data
- hold_fetch  out  1  combinational; PC and IF/ID must not advance

## Operation
- Bubble = all EXE_* outputs zero; opcode 0 decodes as no-op (operation 0, no memory access).
- EXE_dest computed at capture: opcode 2 -> ID_rd; opcode 7 (jal) -> 31; otherwise ID_rt.
- Load = EXE_valid & EXE_opcode==2 & EXE_funct==6'h21.
- hazard = load & EXE_reg_write & EXE_dest!=0 & ID_valid & (ID_rs==EXE_dest | ID_rt==EXE_dest).
- States: RUN, STALL; counter cnt (2 bits).
- Per-edge priority: rst > flush > ext_stall > STALL/hazard > normal.
  - rst: bubble, state RUN, cnt 0.
  - flush: bubble, state RUN, cnt 0 (STALL abandoned).
  - ext_stall: all EXE_* hold, state and cnt hold.
  - RUN & hazard: bubble; if LOAD_USE_BUBBLES==1 stay RUN, else STALL, cnt=LOAD_USE_BUBBLES-2.
  - STALL: bubble; cnt==0 -> RUN, else cnt-1.
  - RUN & no hazard: capture all ID_* (ID_valid=0 captures as bubble).
- hold_fetch = !flush & (ext_stall | state==STALL | (state==RUN & hazard)).

## Timing
- Capture latency 1 cycle: ID value at edge N visible on EXE_* after edge N.
- Reset value: every EXE_* output 0; hold_fetch 0 while rst asserted and after reset.
- Load-use: exactly LOAD_USE_BUBBLES consecutive bubbles, then the dependent instruction is captured on the next edge.
- hazard evaluated only in RUN; STALL ignores hazard.
- flush and ext_stall same cycle: flush wins, hold_fetch 0.
- Reset mid-STALL: returns to RUN, no residual bubbles.

## Configuration
- LOAD_USE_STALL_EN defined: hazard detection, STALL state and counter present as above.
- Undefined: hazard tied 0, state stays RUN; LOAD_USE_BUBBLES ignored; hold_fetch = !flush & ext_stall; load-use handled by software scheduling.

## Test plan
- Reset: rst high 2 cycles with ID_valid=1, opcode 4 -> all EXE_* 0, hold_fetch 0.
- Pass-through: ID opcode 2, funct 6'h20, rd 5, rs_data 7 -> next cycle EXE_opcode 2, funct 6'h20, EXE_dest 5, EXE_rs_data 7; jal -> EXE_dest 31.
- Load-use (macro on, BUBBLES=1): EXE load, dest 8; ID rs=8 -> hold_fetch 1 one cycle, one bubble, dependent captured next edge; dest 0 -> no stall.
- BUBBLES=3: same hazard -> hold_fetch 1 for 3 cycles, 3 bubbles; flush in 2nd cycle -> bubble, RUN, hold_fetch 0.
- ext_stall 2 cycles with EXE holding sub -> EXE_* unchanged, hold_fetch 1; flush with ext_stall -> bubble.
- Macro off: same load-use stimulus -> no bubble, dependent captured immediately.
